pwm_frame_engine: RTL

//  Next-generation PWM output stage for the transducer array, generalised in counter width and alignment mode.

---
 rtl/pwm_frame_if.sv | 33 +++
 rtl/pwm_frame_engine.sv | 119 +++++++++++
 2 files changed

// File: rtl/pwm_frame_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_frame_if
// Brief    : Word stream, period timing and status bundle for pwm_frame_engine.
// Revision : 1.0
// ============================================================================
interface pwm_frame_if #(
    parameter int DEPTH = 249,
    parameter int CNT_W = 9
) ();
    logic             mode;
    logic [CNT_W-1:0] time_cnt;
    logic             update;
    logic             din_valid;
    logic [CNT_W-1:0] pulse_width;
    logic [CNT_W-1:0] phase;
    logic             clear_err;
    logic [DEPTH-1:0] pwm_out;
    logic             dout_valid;
    logic             frame_pending;
    logic             overrun;

    modport master (
        output mode, time_cnt, update, din_valid, pulse_width, phase, clear_err,
        input  pwm_out, dout_valid, frame_pending, overrun
    );

    modport slave (
        input  mode, time_cnt, update, din_valid, pulse_width, phase, clear_err,
        output pwm_out, dout_valid, frame_pending, overrun
    );
endinterface
`default_nettype wire

// File: rtl/pwm_frame_engine.sv
`default_nettype none
// ============================================================================
// Module   : pwm_frame_engine
// Brief    : Double-buffered PWM output stage; edges precomputed per word into
//            a shadow frame, swapped atomically into the active set on update.
// Revision : 1.0
// ============================================================================
module pwm_frame_engine #(
    parameter int DEPTH = 249,
    parameter int CNT_W = 9
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    pwm_frame_if.slave bus
);
    localparam int                 c_idx_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DEPTH - 1);

    logic [c_idx_w-1:0] r_idx;
    logic               r_frame_pending;
    logic               r_overrun;
    logic               r_dout_valid;

    logic               w_word_last;
    logic               w_ovr_set;
    logic               w_swap;
    logic [CNT_W-1:0]   w_rise;
    logic [CNT_W-1:0]   w_fall;
    logic               w_zero;

    always_comb begin
        w_word_last = bus.din_valid && (r_idx == c_last_idx);
        w_ovr_set   = bus.din_valid && (r_idx == '0) && r_frame_pending;
        w_swap      = bus.update && r_frame_pending;
        // Edges wrap naturally at CNT_W bits, giving mod-T arithmetic.
        w_rise      = bus.mode ? bus.phase : (bus.phase - (bus.pulse_width >> 1));
        w_fall      = w_rise + bus.pulse_width;
        w_zero      = (bus.pulse_width == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx           <= '0;
            r_frame_pending <= 1'b0;
            r_overrun       <= 1'b0;
            r_dout_valid    <= 1'b0;
        end else begin
            r_dout_valid <= w_swap;
            if (bus.din_valid) begin
                r_idx <= w_word_last ? '0 : (r_idx + c_idx_w'(1));
            end
            if (w_word_last) begin
                r_frame_pending <= 1'b1;
            end else if (w_ovr_set || w_swap) begin
                r_frame_pending <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (bus.clear_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.dout_valid    = r_dout_valid;
    assign bus.frame_pending = r_frame_pending;
    assign bus.overrun       = r_overrun;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ch
        logic [CNT_W-1:0] r_sh_rise;
        logic [CNT_W-1:0] r_sh_fall;
        logic             r_sh_zero;
        logic [CNT_W-1:0] r_act_rise;
        logic [CNT_W-1:0] r_act_fall;
        logic             r_act_zero;
        logic             r_pwm;
        logic             w_hit;

        // Shadow contents are only consumed after a full frame, so no reset.
        always_ff @(posedge clk) begin
            if (bus.din_valid && (r_idx == c_idx_w'(gi))) begin
                r_sh_rise <= w_rise;
                r_sh_fall <= w_fall;
                r_sh_zero <= w_zero;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_act_rise <= '0;
                r_act_fall <= '0;
                r_act_zero <= 1'b1;
                r_pwm      <= 1'b0;
            end else begin
                if (w_swap) begin
                    r_act_rise <= r_sh_rise;
                    r_act_fall <= r_sh_fall;
                    r_act_zero <= r_sh_zero;
                end
                r_pwm <= w_hit;
            end
        end

        always_comb begin
            w_hit = 1'b0;
            if (r_act_zero) begin
                w_hit = 1'b0;
            end else if (r_act_rise <= r_act_fall) begin
                w_hit = (bus.time_cnt >= r_act_rise) && (bus.time_cnt < r_act_fall);
            end else begin
                w_hit = (bus.time_cnt >= r_act_rise) || (bus.time_cnt < r_act_fall);
            end
        end

        assign bus.pwm_out[gi] = r_pwm;
    end

endmodule
`default_nettype wire
